// File: rtl/vga_pattern_gen.sv
// Resolution-generic VGA timing generator with a frame-synchronous 4-mode test pattern.
// Every video output is registered once, so all of them share a single clock of latency.
module vga_pattern_gen #(
   parameter int H_ACTIVE     = 1280,
   parameter int H_FP         = 48,
   parameter int H_SYNC       = 112,
   parameter int H_BP         = 248,
   parameter int V_ACTIVE     = 1024,
   parameter int V_FP         = 1,
   parameter int V_SYNC       = 3,
   parameter int V_BP         = 38,
   parameter bit HS_POL       = 1'b1,
   parameter bit VS_POL       = 1'b1,
   parameter int STRIPE_SHIFT = 4,
   parameter int CNT_W        = 11
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [1:0]       mode,
   output logic             hsync,
   output logic             vsync,
   output logic             vidon,
   output logic [CNT_W-1:0] hc,
   output logic [CNT_W-1:0] vc,
   output logic [2:0]       red,
   output logic [2:0]       green,
   output logic [1:0]       blue,
   output logic             frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

   typedef enum logic [1:0] {
      PAT_HSTRIPES = 2'd0,
      PAT_VSTRIPES = 2'd1,
      PAT_CHECKER  = 2'd2,
      PAT_BARS     = 2'd3
   } pattern_e;

   logic [CNT_W-1:0] x, y;
   logic [CNT_W-1:0] sub;
   logic [2:0]       bar;
   pattern_e         active_mode;

   logic       x_last, y_last;
   logic       act, hs_a, vs_a;
   logic [2:0] bar_idx;
   logic [7:0] pix;

   assign x_last = (x == H_LAST);
   assign y_last = (y == V_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) begin
         x <= '0;
         y <= '0;
      end else if (x_last) begin
         x <= '0;
         y <= y_last ? '0 : y + 1'b1;
      end else begin
         x <= x + 1'b1;
      end
   end

   // Bar position is tracked incrementally so no divider is needed; bar saturates at 7 in blanking.
   always_ff @(posedge clk) begin
      if (clr || x_last) begin
         sub <= '0;
         bar <= '0;
      end else if (sub == BAR_LAST) begin
         sub <= '0;
         if (bar != 3'd7) bar <= bar + 3'd1;
      end else begin
         sub <= sub + 1'b1;
      end
   end

   // Sampling only on the last pixel of the frame keeps a frame single-mode.
   always_ff @(posedge clk) begin
      if (clr)                  active_mode <= PAT_HSTRIPES;
      else if (x_last && y_last) active_mode <= pattern_e'(mode);
   end

   assign act  = (x < H_ACT) && (y < V_ACT);
   assign hs_a = (x >= HS_START) && (x < HS_END);
   assign vs_a = (y >= VS_START) && (y < VS_END);

   // NOTE: pix gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      pix     = 8'h00;
      bar_idx = 3'd7 - bar;
      if (act) begin
         case (active_mode)
            PAT_HSTRIPES: pix = y[STRIPE_SHIFT] ? 8'hFF : 8'h00;
            PAT_VSTRIPES: pix = x[STRIPE_SHIFT] ? 8'hFF : 8'h00;
            PAT_CHECKER:  pix = (x[STRIPE_SHIFT] ^ y[STRIPE_SHIFT]) ? 8'hFF : 8'h00;
            PAT_BARS:     pix = {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {2{bar_idx[0]}}};
            default:      pix = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         hsync              <= ~HS_POL;
         vsync              <= ~VS_POL;
         vidon              <= 1'b0;
         hc                 <= '0;
         vc                 <= '0;
         {red, green, blue} <= 8'h00;
         frame_start        <= 1'b0;
      end else begin
         hsync              <= hs_a ? HS_POL : ~HS_POL;
         vsync              <= vs_a ? VS_POL : ~VS_POL;
         vidon              <= act;
         hc                 <= x;
         vc                 <= y;
         {red, green, blue} <= pix;
         frame_start        <= (x == '0) && (y == '0);
      end
   end

endmodule
